// File: rtl/key_conditioner_if.sv
// Handshake bundle between the switch conditioner and its neighbours:
// raw switch levels and enable in, conditioned keys and pulses out.
interface key_conditioner_if #(
    parameter int NOTE_KEYS   = 7,
    parameter int LENGTH_KEYS = 4
);
    logic                   en;
    logic [NOTE_KEYS-1:0]   raw_note;
    logic [LENGTH_KEYS-1:0] raw_length;
    logic                   raw_oct_up;
    logic                   raw_oct_down;
    logic [NOTE_KEYS-1:0]   note_key;
    logic [LENGTH_KEYS-1:0] length_key;
    logic                   oct_up;
    logic                   oct_down;
    logic                   en_hit;

    modport master (
        output en, raw_note, raw_length, raw_oct_up, raw_oct_down,
        input  note_key, length_key, oct_up, oct_down, en_hit
    );

    modport slave (
        input  en, raw_note, raw_length, raw_oct_up, raw_oct_down,
        output note_key, length_key, oct_up, oct_down, en_hit
    );
endinterface

// File: rtl/key_conditioner.sv
// Synchronises and debounces panel switches, priority-encodes note/length
// keys, and turns octave button presses into single-cycle step pulses.
module key_debounce #(
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic db
);
    localparam int CW = $clog2(DEBOUNCE_CNT);

    logic [1:0]    sync_ff;
    logic [CW-1:0] cnt;
    logic          sync;

    assign sync = sync_ff[1];

    // cnt saturates at DEBOUNCE_CNT-1: that edge either accepts or clears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff <= '0;
            cnt     <= '0;
            db      <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[0], raw};
            if (sync == db) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CNT - 1)) begin
                db  <= sync;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

module key_conditioner #(
    parameter int NOTE_KEYS    = 7,
    parameter int LENGTH_KEYS  = 4,
    parameter int DEBOUNCE_CNT = 1000000
) (
    input  logic                clk,
    input  logic                rst_n,
    key_conditioner_if.slave    bus
);
    localparam int NUM_IN = NOTE_KEYS + LENGTH_KEYS + 2;

    logic [NUM_IN-1:0]      raw_all;
    logic [NUM_IN-1:0]      db_all;
    logic [NOTE_KEYS-1:0]   db_note;
    logic [LENGTH_KEYS-1:0] db_length;
    logic                   db_up;
    logic                   db_down;
    logic [NOTE_KEYS-1:0]   note_enc;
    logic [LENGTH_KEYS-1:0] length_enc;
    logic [NOTE_KEYS-1:0]   note_reg;
    logic                   up_q;
    logic                   down_q;
    logic                   up_rise;
    logic                   down_rise;

    assign raw_all = {bus.raw_oct_down, bus.raw_oct_up, bus.raw_length, bus.raw_note};

    for (genvar i = 0; i < NUM_IN; i++) begin : g_db
        key_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (raw_all[i]),
            .db    (db_all[i])
        );
    end

    assign db_note   = db_all[NOTE_KEYS-1:0];
    assign db_length = db_all[NOTE_KEYS +: LENGTH_KEYS];
    assign db_up     = db_all[NUM_IN-2];
    assign db_down   = db_all[NUM_IN-1];

    // x & -x isolates the lowest set bit: one-hot or zero
    assign note_enc   = db_note & (~db_note + NOTE_KEYS'(1));
    assign length_enc = db_length & (~db_length + LENGTH_KEYS'(1));

    assign up_rise   = db_up & ~up_q;
    assign down_rise = db_down & ~down_q;

    // note_reg tracks the key regardless of en, so raising en on a held
    // key shows it without counting as a new strike
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            note_reg       <= '0;
            up_q           <= 1'b0;
            down_q         <= 1'b0;
            bus.note_key   <= '0;
            bus.length_key <= '0;
            bus.en_hit     <= 1'b0;
            bus.oct_up     <= 1'b0;
            bus.oct_down   <= 1'b0;
        end else begin
            note_reg       <= note_enc;
            up_q           <= db_up;
            down_q         <= db_down;
            bus.note_key   <= bus.en ? note_enc : '0;
            bus.length_key <= bus.en ? length_enc : '0;
            bus.en_hit     <= bus.en && (note_enc != note_reg) && (|note_enc);
            bus.oct_up     <= bus.en & up_rise & ~down_rise;
            bus.oct_down   <= bus.en & down_rise & ~up_rise;
        end
    end
endmodule
